vga_timing_gen: RTL and testbench

- Display timing generator for the 640x480 @ 60 Hz VGA path.
- Produces the pixel row/column addresses that drive the world-map and icon lookups.
- Produces the video_on, horiz_sync and vert_sync levels that the pixel colour stage consumes.
- Contains a programmable delay line so video_on and both syncs line up with the registered latency of the map/icon lookups.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_timing_gen_sync_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and shared types.
// Frame geometry, counter width and the sync polarity encoding.
package vga_timing_pkg;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL =
        DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL =
        DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam logic SYNC_ACT_LOW  = 1'b0;
    localparam logic SYNC_ACT_HIGH = 1'b1;

    typedef struct packed {
        logic video;
        logic hs;
        logic vs;
    } vga_ctl_t;

    function automatic bit totals_ok(input int h_total,
                                     input int v_total);
        return (h_total <= CNT_MAX) && (v_total <= CNT_MAX);
    endfunction

    localparam bit DEF_TOTALS_OK =
        totals_ok(DEF_H_TOTAL, DEF_V_TOTAL);

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Enable-gated shift register aligning video/sync flags with lookup latency.
// DEPTH=0 degenerates to a wire.
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctl;
        assign unused_ctl = ^{clk, reset, en};
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else if (en) begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with position decode and delayed video/sync outputs.
// Decode works on the next count so PIPE_DLY=0 matches the live counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = SYNC_ACT_LOW,
    parameter int   PIPE_DLY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] pixel_column,
    output logic [CNT_W-1:0] pixel_row,
    output logic             video_on,
    output logic             horiz_sync,
    output logic             vert_sync,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (!totals_ok(H_TOTAL, V_TOTAL)) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam vga_ctl_t CTL_RST = '{
        video: 1'b0,
        hs:    ~SYNC_POL,
        vs:    ~SYNC_POL
    };

    logic [CNT_W-1:0] h_q, v_q;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             h_wrap, v_wrap;
    vga_ctl_t         dec_nxt, dec_q, dly_q;

    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_nxt  = h_wrap ? '0 : h_q + 1'b1;
        v_nxt  = v_q;
        if (h_wrap) v_nxt = v_wrap ? '0 : v_q + 1'b1;
    end

    always_comb begin
        dec_nxt.video = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        dec_nxt.hs    = (h_nxt >= HS_LO && h_nxt <= HS_HI)
                      ? SYNC_POL : ~SYNC_POL;
        dec_nxt.vs    = (v_nxt >= VS_LO && v_nxt <= VS_HI)
                      ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q         <= '0;
            v_q         <= '0;
            dec_q       <= CTL_RST;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                h_q   <= h_nxt;
                v_q   <= v_nxt;
                dec_q <= dec_nxt;
            end
        end
    end

    sync_delay_line #(
        .WIDTH   ($bits(vga_ctl_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (CTL_RST)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .d     (dec_q),
        .q     (dly_q)
    );

    assign pixel_column = h_q;
    assign pixel_row    = v_q;
    assign video_on     = dly_q.video;
    assign horiz_sync   = dly_q.hs;
    assign vert_sync    = dly_q.vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench: four timing generators checked against a tick-count model.
// Position, decode and frame pulse are derived from ticks since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp;
    } geo_t;

    localparam geo_t GEO_DEF = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam geo_t GEO_SM  = '{8, 2, 3, 2, 6, 1, 2, 1};

    logic       clk;
    logic       reset;
    logic       pix_en;
    logic [9:0] col [4];
    logic [9:0] row [4];
    logic [3:0] vo, hs, vs, fs;

    longint n;
    bit     en_last;
    int     n_chk;
    int     n_fail;

    vga_timing_gen #(.PIPE_DLY(0), .SYNC_POL(1'b0)) u_d0 (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .pixel_column(col[0]), .pixel_row(row[0]),
        .video_on(vo[0]), .horiz_sync(hs[0]), .vert_sync(vs[0]),
        .frame_start(fs[0])
    );

    vga_timing_gen #(.PIPE_DLY(2), .SYNC_POL(1'b0)) u_d2 (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .pixel_column(col[1]), .pixel_row(row[1]),
        .video_on(vo[1]), .horiz_sync(hs[1]), .vert_sync(vs[1]),
        .frame_start(fs[1])
    );

    vga_timing_gen #(.PIPE_DLY(1), .SYNC_POL(1'b1)) u_p1 (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .pixel_column(col[2]), .pixel_row(row[2]),
        .video_on(vo[2]), .horiz_sync(hs[2]), .vert_sync(vs[2]),
        .frame_start(fs[2])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .PIPE_DLY(3)
    ) u_sm (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .pixel_column(col[3]), .pixel_row(row[3]),
        .video_on(vo[3]), .horiz_sync(hs[3]), .vert_sync(vs[3]),
        .frame_start(fs[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (tick %0d, t=%0t)",
                     tag, got, exp, n, $time);
        end
    endtask

    // t = enabled ticks since reset; d = output delay in ticks
    function automatic logic [23:0] model(input geo_t g, input int d,
                                          input logic pol,
                                          input longint t,
                                          input bit el);
        longint     ht, vt, m;
        int         h, v;
        logic [2:0] ctl;
        logic       f;
        logic [9:0] c, r;
        ht = g.ha + g.hfp + g.hs + g.hbp;
        vt = g.va + g.vfp + g.vs + g.vbp;
        c  = 10'(t % ht);
        r  = 10'((t / ht) % vt);
        if (t <= longint'(d)) begin
            ctl = {1'b0, ~pol, ~pol};
        end else begin
            m = t - d;
            h = int'(m % ht);
            v = int'((m / ht) % vt);
            ctl[2] = (h < g.ha) && (v < g.va);
            ctl[1] = (h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hs)
                   ? pol : ~pol;
            ctl[0] = (v >= g.va + g.vfp && v < g.va + g.vfp + g.vs)
                   ? pol : ~pol;
        end
        f = el && (t > 0) && ((t % (ht * vt)) == 0);
        return {r, c, ctl, f};
    endfunction

    function automatic logic [23:0] dut_vec(input int i);
        return {row[i], col[i], vo[i], hs[i], vs[i], fs[i]};
    endfunction

    task automatic compare_all();
        check("d0_def_dly0", 32'(dut_vec(0)),
              32'(model(GEO_DEF, 0, 1'b0, n, en_last)));
        check("d2_def_dly2", 32'(dut_vec(1)),
              32'(model(GEO_DEF, 2, 1'b0, n, en_last)));
        check("p1_pol_high", 32'(dut_vec(2)),
              32'(model(GEO_DEF, 1, 1'b1, n, en_last)));
        check("sm_small_dly3", 32'(dut_vec(3)),
              32'(model(GEO_SM, 3, 1'b0, n, en_last)));
    endtask

    task automatic step(input logic rst, input logic en);
        reset  = rst;
        pix_en = en;
        @(posedge clk);
        if (rst) begin
            n       = 0;
            en_last = 1'b0;
        end else if (en) begin
            n++;
            en_last = 1'b1;
        end else begin
            en_last = 1'b0;
        end
        #1;
        compare_all();
    endtask

    initial begin
        int fs_cnt;
        int sm_frame;
        n        = 0;
        en_last  = 1'b0;
        n_chk    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        pix_en   = 1'b1;
        sm_frame = (GEO_SM.ha + GEO_SM.hfp + GEO_SM.hs + GEO_SM.hbp)
                 * (GEO_SM.va + GEO_SM.vfp + GEO_SM.vs + GEO_SM.vbp);

        step(1'b1, 1'b1);
        step(1'b1, 1'b0);

        fs_cnt = 0;
        repeat (2000) begin
            step(1'b0, 1'b1);
            if (fs[3]) fs_cnt++;
        end
        check("sm_frame_pulses", 32'(fs_cnt), 32'(2000 / sm_frame));

        repeat (1500) step(1'b0, 1'($urandom_range(0, 1)));

        step(1'b1, 1'b1);
        repeat (1700) step(1'b0, 1'b1);

        for (int i = 0; i < 1200; i++) step(1'b0, (i % 4) == 3);

        repeat (800)
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
